// File: rtl/tsf_sched_pkg.sv
// Shared defaults and load-sequence state encoding for the TSF event scheduler.
package tsf_sched_pkg;

  localparam int TSF_TIMER_WIDTH = 64;
  localparam int TSF_NUM_EVT     = 4;

  // Load sequence: hold strobe high, drop it so the timer loads on the
  // falling edge, then allow one settle cycle before compares resume.
  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_ASSERT  = 2'd1,
    LD_RELEASE = 2'd2,
    LD_SETTLE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/tsf_evt_chan.sv
// One event channel: compares the running TSF against its target, fires,
// reloads periodic targets and keeps the sticky status/overflow flags.
module tsf_evt_chan
  import tsf_sched_pkg::*;
#(
  parameter int TIMER_WIDTH = TSF_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [TIMER_WIDTH-1:0] i_tsf,
  input  logic                   i_cmp_en,
  input  logic                   i_arm,
  input  logic                   i_disarm,
  input  logic [TIMER_WIDTH-1:0] i_target,
  input  logic [TIMER_WIDTH-1:0] i_period,
  input  logic                   i_clr,
  output logic                   o_fire,
  output logic                   o_status,
  output logic                   o_ovf,
  output logic                   o_armed
);

  logic [TIMER_WIDTH-1:0] r_target;
  logic [TIMER_WIDTH-1:0] r_period;
  logic                   r_fire;
  logic                   r_status;
  logic                   r_ovf;
  logic                   r_armed;

  logic                   w_hit;
  logic                   w_write;
  logic                   w_fire_set;
  logic [TIMER_WIDTH:0]   w_next_target;

  // A host write to this channel in the hit cycle takes precedence over the hit.
  assign w_write       = i_arm | i_disarm;
  assign w_hit         = r_armed & i_cmp_en & (i_tsf >= r_target);
  assign w_fire_set    = w_hit & ~w_write;
  // Extra top bit catches wrap-around of the periodic reload.
  assign w_next_target = {1'b0, r_target} + {1'b0, r_period};

  // Channel state: arm/disarm writes, hit handling with reload/overflow, flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_target <= {TIMER_WIDTH{1'b0}};
      r_period <= {TIMER_WIDTH{1'b0}};
      r_fire   <= 1'b0;
      r_status <= 1'b0;
      r_ovf    <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_fire <= w_fire_set;

      // Setting wins over a simultaneous write-1-to-clear.
      if (w_fire_set) begin
        r_status <= 1'b1;
      end else if (i_clr) begin
        r_status <= 1'b0;
      end else begin
        r_status <= r_status;
      end

      if (i_arm) begin
        r_target <= i_target;
        r_period <= i_period;
        r_armed  <= 1'b1;
        r_ovf    <= 1'b0;
      end else if (i_disarm) begin
        r_armed <= 1'b0;
      end else if (w_hit) begin
        if (r_period == {TIMER_WIDTH{1'b0}}) begin
          r_armed <= 1'b0;
        end else if (w_next_target[TIMER_WIDTH]) begin
          r_armed <= 1'b0;
          r_ovf   <= 1'b1;
        end else begin
          r_target <= w_next_target[TIMER_WIDTH-1:0];
        end
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  assign o_fire   = r_fire;
  assign o_status = r_status;
  assign o_ovf    = r_ovf;
  assign o_armed  = r_armed;

endmodule

// File: rtl/tsf_event_scheduler.sv
// TSF event scheduler top: host-driven timer load sequence plus NUM_EVT
// independent compare channels that are muted while a load is in flight.
module tsf_event_scheduler
  import tsf_sched_pkg::*;
#(
  parameter  int TIMER_WIDTH = TSF_TIMER_WIDTH,
  parameter  int NUM_EVT     = TSF_NUM_EVT,
  localparam int IDX_W       = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
  input  logic                   load_req,
  input  logic [TIMER_WIDTH-1:0] load_val,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   tsf_load_control,
  output logic [TIMER_WIDTH-1:0] tsf_load_val,
  input  logic                   arm_we,
  input  logic [IDX_W-1:0]       arm_idx,
  input  logic [TIMER_WIDTH-1:0] arm_target,
  input  logic [TIMER_WIDTH-1:0] arm_period,
  input  logic                   disarm_we,
  output logic [NUM_EVT-1:0]     evt_fire,
  output logic [NUM_EVT-1:0]     evt_status,
  input  logic [NUM_EVT-1:0]     evt_clr,
  output logic [NUM_EVT-1:0]     evt_ovf,
  output logic [NUM_EVT-1:0]     evt_armed
);

  load_state_e            r_state;
  logic                   r_assert_cnt;
  logic                   r_load_ctrl;
  logic [TIMER_WIDTH-1:0] r_load_val;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_cmp_en;
  logic [NUM_EVT-1:0]     w_arm;
  logic [NUM_EVT-1:0]     w_disarm;

  // Load sequencer with registered strobe, busy and done outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= LD_IDLE;
      r_assert_cnt <= 1'b0;
      r_load_ctrl  <= 1'b0;
      r_load_val   <= {TIMER_WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        LD_IDLE: begin
          r_done <= 1'b0;
          if (load_req) begin
            r_load_val   <= load_val;
            r_load_ctrl  <= 1'b1;
            r_busy       <= 1'b1;
            r_assert_cnt <= 1'b0;
            r_state      <= LD_ASSERT;
          end
        end
        LD_ASSERT: begin
          // Strobe stays high for two cycles before being dropped.
          if (r_assert_cnt) begin
            r_load_ctrl <= 1'b0;
            r_state     <= LD_RELEASE;
          end else begin
            r_assert_cnt <= 1'b1;
          end
        end
        LD_RELEASE: begin
          r_done  <= 1'b1;
          r_state <= LD_SETTLE;
        end
        LD_SETTLE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= LD_IDLE;
        end
        default: begin
          r_load_ctrl <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= LD_IDLE;
        end
      endcase
    end
  end

  assign w_cmp_en = (r_state == LD_IDLE);

  // Route arm/disarm strobes to the addressed channel only.
  always_comb begin
    w_arm    = {NUM_EVT{1'b0}};
    w_disarm = {NUM_EVT{1'b0}};
    for (int i = 0; i < NUM_EVT; i++) begin
      if (arm_idx == IDX_W'(i)) begin
        w_arm[i]    = arm_we;
        w_disarm[i] = disarm_we;
      end else begin
        w_arm[i]    = 1'b0;
        w_disarm[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_chan
    tsf_evt_chan #(
      .TIMER_WIDTH (TIMER_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .i_tsf    (tsf_runtime_val),
      .i_cmp_en (w_cmp_en),
      .i_arm    (w_arm[g]),
      .i_disarm (w_disarm[g]),
      .i_target (arm_target),
      .i_period (arm_period),
      .i_clr    (evt_clr[g]),
      .o_fire   (evt_fire[g]),
      .o_status (evt_status[g]),
      .o_ovf    (evt_ovf[g]),
      .o_armed  (evt_armed[g])
    );
  end

  assign load_busy        = r_busy;
  assign load_done        = r_done;
  assign tsf_load_control = r_load_ctrl;
  assign tsf_load_val     = r_load_val;

endmodule

// File: doc/tsf_event_scheduler.md
TSF_EVENT_SCHEDULER -- requirements
Module: tsf_event_scheduler

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64, width of TSF values.
REQ-002 SHALL have parameter NUM_EVT, default 4, number of independent event channels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 tsf_runtime_val  input  TIMER_WIDTH  current TSF count from the timer.
REQ-006 load_req  input  1  one-cycle host request to load a new TSF value.
REQ-007 load_val  input  TIMER_WIDTH  value to load, sampled with load_req.
REQ-008 load_busy  output  1  high while a load sequence is in progress.
REQ-009 load_done  output  1  one-cycle pulse when a load sequence completes.
REQ-010 tsf_load_control  output  1  load strobe to the timer.
REQ-011 tsf_load_val  output  TIMER_WIDTH  load value to the timer.
REQ-012 arm_we  input  1  one-cycle write strobe that arms the channel selected by arm_idx.
REQ-013 arm_idx  input  clog2(NUM_EVT)  channel index for arm_we and disarm.
REQ-014 arm_target  input  TIMER_WIDTH  first fire time, in TSF ticks.
REQ-015 arm_period  input  TIMER_WIDTH  reload period; 0 means one-shot.
REQ-016 disarm_we  input  1  one-cycle strobe that disarms channel arm_idx.
REQ-017 evt_fire  output  NUM_EVT  per-channel one-cycle fire pulse.
REQ-018 evt_status  output  NUM_EVT  sticky per-channel fired flag.
REQ-019 evt_clr  input  NUM_EVT  write-1-to-clear for evt_status.
REQ-020 evt_ovf  output  NUM_EVT  sticky flag: periodic reload overflowed; cleared only by re-arm or reset.
REQ-021 evt_armed  output  NUM_EVT  current armed state per channel.

Function
REQ-022 Load FSM states: IDLE, ASSERT, RELEASE, SETTLE.
REQ-023 In IDLE, load_req SHALL latch load_val into tsf_load_val and move to ASSERT.
REQ-024 ASSERT SHALL drive tsf_load_control=1 for exactly 2 cycles, then move to RELEASE.
REQ-025 RELEASE SHALL drive tsf_load_control=0 for 1 cycle, producing the falling edge on which the timer loads; the FSM then moves to SETTLE.
REQ-026 SETTLE SHALL last 1 cycle, pulse load_done, and return to IDLE.
REQ-027 load_busy SHALL be 1 in every state except IDLE; load_req while busy SHALL be ignored, with no queueing.
REQ-028 Per channel, hit = armed AND (tsf_runtime_val >= target, unsigned) AND load FSM in IDLE.
REQ-029 On hit at edge t, evt_fire SHALL be high for the cycle after t (1-cycle latency) and evt_status SHALL set at the same edge.
REQ-030 On hit with period=0, the channel SHALL disarm.
REQ-031 On hit with period≠0, target SHALL become target+period at the same edge, so the channel cannot fire twice for one target.
REQ-032 If target+period overflows TIMER_WIDTH, the channel SHALL disarm and set evt_ovf, and evt_fire for that hit SHALL still occur.
REQ-033 arm_we SHALL load target/period, set armed, and clear evt_ovf; a target already in the past SHALL fire on the next edge.
REQ-034 arm_we or disarm_we to a channel that hits in the same cycle: the write wins and no fire occurs.
REQ-035 arm_we and disarm_we in the same cycle: arm_we wins.
REQ-036 evt_clr and a set of evt_status in the same cycle: set wins.
REQ-037 Multiple channels MAY fire in the same cycle, and each SHALL be independent.
REQ-038 Hits SHALL be suppressed during load states (ASSERT, RELEASE, SETTLE); after IDLE is re-entered, compares SHALL resume against the new TSF.

Reset
REQ-039 When rstn=0 at a clock edge, the load FSM SHALL go to IDLE and all outputs SHALL be 0: tsf_load_control, tsf_load_val, load_busy, load_done, evt_fire, evt_status, evt_ovf, evt_armed.
REQ-040 Reset SHALL clear all targets and periods to 0, and SHALL take effect immediately, including mid-load or mid-fire.

Structure
REQ-041 Package tsf_sched_pkg SHALL hold the TIMER_WIDTH/NUM_EVT defaults and the load FSM state enumeration.
REQ-042 Per-channel compare/reload/flag logic SHALL be sub-module tsf_evt_chan, instantiated NUM_EVT times; the load FSM and arming decode stay in the top.

Verification
REQ-043 Arm ch0 target=100, period=0; TSF ramps from 90 -> evt_fire[0] pulses once, at the cycle after TSF=100; then evt_armed[0]=0 and evt_status[0]=1.
REQ-044 Arm ch1 target=50, period=20 -> fires after TSF=50, 70, 90; evt_clr[1] together with a fire leaves evt_status[1]=1.
REQ-045 load_req with load_val=0x1000 while TSF=500 -> tsf_load_control is 1,1,0 over 3 cycles, load_done on the 4th cycle; a second load_req inside that window is ignored; load_busy=1 for 4 cycles.
REQ-046 Ch2 armed target=600 with a load to 1000 issued at TSF=590 -> no fire during the load; fire on the first compare after IDLE.
REQ-047 Arm ch3 target=2^64-5, period=10 -> one fire, then evt_ovf[3]=1 and evt_armed[3]=0.
REQ-048 Assert rstn=0 during ASSERT -> next cycle all outputs 0, FSM IDLE, all channels disarmed.
